// File: rtl/m68k_bus_responder_pkg.sv
// m68k_bus_responder_pkg
//   Shared core definitions for the 68k bus-cycle responder: the board-level
//   (pcb_*) default wait/timeout constants, the responder state encoding and
//   saturating 8-bit counter helpers.
package m68k_bus_responder_pkg;

  // Board defaults for the responder's wait timing.
  localparam int PCB_RAM_WAIT    = 0;    // work RAM, palette/tile/sprite registers
  localparam int PCB_SHARED_WAIT = 2;    // Z80 shared RAM
  localparam int PCB_TIMEOUT     = 255;  // cycles before an unanswered cycle is bus-errored

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ROM    = 3'd3,
    ST_ACK    = 3'd4,
    ST_BERR   = 3'd5
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

endpackage

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder
//   Answers 68000 bus cycles: waits a fixed number of cycles for RAM/register
//   and shared-RAM accesses, handshakes with SDRAM for program-ROM reads, and
//   raises a bus error for cycles nobody answers.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high
//   cpu_as_n     68k address strobe
//   cpu_rw       1 = read, 0 = write
//   cpu_uds_n    upper data strobe
//   cpu_lds_n    lower data strobe
//   rom_sel      OR of program-ROM selects
//   fast_sel     OR of RAM/register selects
//   shared_sel   shared-RAM select
//   rom_ack      one-cycle pulse from SDRAM when ROM data is valid
//   cpu_dtack_n  data acknowledge to the 68k (low throughout ACK)
//   cpu_berr_n   bus error to the 68k (low throughout BERR)
//   rom_req      level request to SDRAM
//   wr_stb       one-cycle write commit pulse
//   rd_stb       one-cycle read latch pulse
//   busy         high whenever a cycle is in progress
module m68k_bus_responder
  import m68k_bus_responder_pkg::*;
#(
  parameter int RAM_WAIT    = PCB_RAM_WAIT,
  parameter int SHARED_WAIT = PCB_SHARED_WAIT,
  parameter int TIMEOUT     = PCB_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_as_n,
  input  logic cpu_rw,
  input  logic cpu_uds_n,
  input  logic cpu_lds_n,
  input  logic rom_sel,
  input  logic fast_sel,
  input  logic shared_sel,
  input  logic rom_ack,
  output logic cpu_dtack_n,
  output logic cpu_berr_n,
  output logic rom_req,
  output logic wr_stb,
  output logic rd_stb,
  output logic busy
);

  localparam logic [7:0] RAM_WAIT_C    = 8'(RAM_WAIT);
  localparam logic [7:0] SHARED_WAIT_C = 8'(SHARED_WAIT);
  localparam logic [7:0] TIMEOUT_C     = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [7:0] tmo_cnt, tmo_cnt_nxt;
  logic       unmapped, unmapped_nxt;
  logic       rw_lat, rw_lat_nxt;
  logic       enter_ack;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    unmapped_nxt = unmapped;
    rw_lat_nxt   = rw_lat;

    case (state)
      ST_IDLE: begin
        wait_cnt_nxt = 8'd0;
        tmo_cnt_nxt  = 8'd0;
        unmapped_nxt = 1'b0;
        if (!cpu_as_n && (!cpu_uds_n || !cpu_lds_n)) begin
          state_nxt = ST_SETTLE;
        end
      end

      // Address decode has had one cycle to settle; sample selects and
      // direction now.
      ST_SETTLE: begin
        tmo_cnt_nxt = 8'd0;
        rw_lat_nxt  = cpu_rw;
        if (cpu_as_n) begin
          state_nxt = ST_IDLE;
        end else if (rom_sel) begin
          state_nxt = ST_ROM;
        end else if (shared_sel) begin
          wait_cnt_nxt = SHARED_WAIT_C;
          state_nxt    = ST_WAIT;
        end else if (fast_sel) begin
          wait_cnt_nxt = RAM_WAIT_C;
          state_nxt    = ST_WAIT;
        end else begin
          // Nothing decoded: sit in WAIT on the timeout and end in BERR.
          wait_cnt_nxt = TIMEOUT_C;
          unmapped_nxt = 1'b1;
          state_nxt    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cpu_as_n) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt == 8'd0) begin
          state_nxt = unmapped ? ST_BERR : ST_ACK;
        end else if (tmo_cnt == TIMEOUT_C) begin
          state_nxt = ST_BERR;
        end else begin
          wait_cnt_nxt = sat_dec(wait_cnt);
          tmo_cnt_nxt  = sat_inc(tmo_cnt);
        end
      end

      ST_ROM: begin
        if (cpu_as_n) begin
          state_nxt = ST_IDLE;
        end else if (rom_ack) begin
          state_nxt = ST_ACK;
        end else if (tmo_cnt == TIMEOUT_C) begin
          state_nxt = ST_BERR;
        end else begin
          tmo_cnt_nxt = sat_inc(tmo_cnt);
        end
      end

      ST_ACK: begin
        if (cpu_as_n) state_nxt = ST_IDLE;
      end

      ST_BERR: begin
        if (cpu_as_n) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_ack = (state_nxt == ST_ACK) && (state != ST_ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
      tmo_cnt  <= 8'd0;
      unmapped <= 1'b0;
      rw_lat   <= 1'b1;
      wr_stb   <= 1'b0;
      rd_stb   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      unmapped <= unmapped_nxt;
      rw_lat   <= rw_lat_nxt;
      wr_stb   <= enter_ack && !rw_lat;
      rd_stb   <= enter_ack &&  rw_lat;
    end
  end

  // rom_req falls combinationally with rom_ack so SDRAM sees the request
  // withdrawn in the same cycle it answers.
  assign rom_req     = (state == ST_ROM) && !rom_ack;
  assign cpu_dtack_n = (state != ST_ACK);
  assign cpu_berr_n  = (state != ST_BERR);
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder
//   Directed bench for m68k_bus_responder with hand-computed expectations.
module tb_m68k_bus_responder;

  logic clk = 1'b0;
  logic reset;
  logic cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n;
  logic rom_sel, fast_sel, shared_sel, rom_ack;
  logic cpu_dtack_n, cpu_berr_n, rom_req, wr_stb, rd_stb, busy;

  int vectors     = 0;
  int miscompares = 0;
  logic seen_dtack;

  always #5 clk = ~clk;

  m68k_bus_responder #(
    .RAM_WAIT(0),
    .SHARED_WAIT(2),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_as_n(cpu_as_n),
    .cpu_rw(cpu_rw),
    .cpu_uds_n(cpu_uds_n),
    .cpu_lds_n(cpu_lds_n),
    .rom_sel(rom_sel),
    .fast_sel(fast_sel),
    .shared_sel(shared_sel),
    .rom_ack(rom_ack),
    .cpu_dtack_n(cpu_dtack_n),
    .cpu_berr_n(cpu_berr_n),
    .rom_req(rom_req),
    .wr_stb(wr_stb),
    .rd_stb(rd_stb),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cpu_as_n   = 1'b1;
    cpu_uds_n  = 1'b1;
    cpu_lds_n  = 1'b1;
    cpu_rw     = 1'b1;
    rom_sel    = 1'b0;
    fast_sel   = 1'b0;
    shared_sel = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rom_ack = 1'b0;
    bus_idle();
    tick(2);
    chk("rst_dtack", cpu_dtack_n, 1'b1);
    chk("rst_berr",  cpu_berr_n,  1'b1);
    chk("rst_romreq", rom_req,    1'b0);
    chk("rst_wrstb", wr_stb,      1'b0);
    chk("rst_rdstb", rd_stb,      1'b0);
    chk("rst_busy",  busy,        1'b0);
    reset = 1'b0;
    tick(1);
    chk("idle_busy", busy, 1'b0);

    // Fast write, RAM_WAIT=0: dtack after 3 edges.
    cpu_as_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw = 1'b0; fast_sel = 1'b1;
    tick(1);
    chk("fw_settle_busy",  busy,        1'b1);
    chk("fw_settle_dtack", cpu_dtack_n, 1'b1);
    tick(1);
    chk("fw_wait_dtack",   cpu_dtack_n, 1'b1);
    tick(1);
    chk("fw_ack_dtack",    cpu_dtack_n, 1'b0);
    chk("fw_ack_wrstb",    wr_stb,      1'b1);
    chk("fw_ack_rdstb",    rd_stb,      1'b0);
    tick(1);
    chk("fw_hold_dtack",   cpu_dtack_n, 1'b0);
    chk("fw_hold_wrstb",   wr_stb,      1'b0);
    bus_idle();
    tick(1);
    chk("fw_rel_dtack",    cpu_dtack_n, 1'b1);
    chk("fw_rel_busy",     busy,        1'b0);

    // Shared read, SHARED_WAIT=2: dtack after 5 edges.
    cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_rw = 1'b1; shared_sel = 1'b1;
    tick(4);
    chk("sr_wait_dtack", cpu_dtack_n, 1'b1);
    chk("sr_wait_rdstb", rd_stb,      1'b0);
    tick(1);
    chk("sr_ack_dtack",  cpu_dtack_n, 1'b0);
    chk("sr_ack_rdstb",  rd_stb,      1'b1);
    chk("sr_ack_wrstb",  wr_stb,      1'b0);
    tick(1);
    chk("sr_hold_rdstb", rd_stb,      1'b0);
    bus_idle();
    tick(1);
    chk("sr_rel_busy",   busy,        1'b0);

    // ROM read, rom_ack 10 cycles after rom_req rises.
    cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw = 1'b1; rom_sel = 1'b1;
    tick(1);
    chk("rom_settle_req", rom_req, 1'b0);
    tick(1);
    chk("rom_req_rise",   rom_req, 1'b1);
    tick(9);
    chk("rom_req_held",   rom_req,     1'b1);
    chk("rom_wait_dtack", cpu_dtack_n, 1'b1);
    tick(1);
    rom_ack = 1'b1;
    #1;
    chk("rom_req_drop",   rom_req,     1'b0);
    chk("rom_ackcyc_dtack", cpu_dtack_n, 1'b1);
    tick(1);
    rom_ack = 1'b0;
    chk("rom_ack_dtack",  cpu_dtack_n, 1'b0);
    chk("rom_ack_rdstb",  rd_stb,      1'b1);
    chk("rom_ack_req",    rom_req,     1'b0);
    bus_idle();
    tick(1);
    chk("rom_rel_busy",   busy,        1'b0);

    // Unmapped write: bus error after the timeout, dtack never asserted.
    cpu_as_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw = 1'b0;
    seen_dtack = 1'b0;
    for (int i = 0; i < 257; i++) begin
      tick(1);
      if (cpu_dtack_n == 1'b0) seen_dtack = 1'b1;
    end
    chk("um_pre_berr",  cpu_berr_n,  1'b1);
    chk("um_busy",      busy,        1'b1);
    tick(1);
    chk("um_berr",      cpu_berr_n,  1'b0);
    chk("um_dtack",     cpu_dtack_n, 1'b1);
    chk("um_wrstb",     wr_stb,      1'b0);
    chk("um_no_dtack",  seen_dtack,  1'b0);
    tick(2);
    chk("um_berr_hold", cpu_berr_n,  1'b0);
    bus_idle();
    tick(1);
    chk("um_rel_berr",  cpu_berr_n,  1'b1);
    chk("um_rel_busy",  busy,        1'b0);

    // ROM cycle aborted by AS release; a late rom_ack is ignored.
    cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_rw = 1'b1; rom_sel = 1'b1;
    tick(2);
    chk("ab_req",      rom_req, 1'b1);
    tick(3);
    bus_idle();
    tick(1);
    chk("ab_req_drop", rom_req, 1'b0);
    chk("ab_busy",     busy,    1'b0);
    chk("ab_rdstb",    rd_stb,  1'b0);
    rom_ack = 1'b1;
    tick(1);
    rom_ack = 1'b0;
    chk("ab_late_dtack", cpu_dtack_n, 1'b1);
    chk("ab_late_rdstb", rd_stb,      1'b0);
    chk("ab_late_busy",  busy,        1'b0);

    // Reset pulsed mid-cycle while in WAIT.
    cpu_as_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw = 1'b1;
    tick(10);
    chk("rw_busy_before", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_busy",   busy,        1'b0);
    chk("rw_dtack",  cpu_dtack_n, 1'b1);
    chk("rw_berr",   cpu_berr_n,  1'b1);
    chk("rw_romreq", rom_req,     1'b0);
    chk("rw_rdstb",  rd_stb,      1'b0);
    #1;
    reset = 1'b0;
    fast_sel = 1'b1;
    tick(1);
    chk("rw_settle_busy",  busy,        1'b1);
    chk("rw_settle_dtack", cpu_dtack_n, 1'b1);
    tick(1);
    chk("rw_wait_dtack",   cpu_dtack_n, 1'b1);
    tick(1);
    chk("rw_ack_dtack",    cpu_dtack_n, 1'b0);
    chk("rw_ack_rdstb",    rd_stb,      1'b1);
    bus_idle();
    tick(1);
    chk("rw_rel_busy",     busy,        1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
